// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with frame-locked camera index
//
// Purpose:
//   Divides sys_clk down to a pixel-enable tick, runs the horizontal and
//   vertical raster counters, and produces registered scan position, sync,
//   blanking, frame-start and a camera index that only changes in vblank.
//
// Ports:
//   sys_clk       in   system clock (only clock)
//   sys_rst       in   asynchronous active-high reset
//   camera_y_req  in   camera block index requested by game logic
//   p_tick        out  one-sys_clk pixel-enable pulse (combinational decode)
//   x, y          out  current horizontal / vertical count
//   video_on      out  high inside the visible 640x480 area
//   hsync, vsync  out  active-low sync pulses
//   vblank        out  high on lines >= V_DISPLAY
//   frame_start   out  one-sys_clk pulse when the position becomes (0,0)
//   camera_y      out  camera index frozen for the current frame

module vga_timing_gen #(
  parameter int SCREEN_WIDTH = 10,
  parameter int CAMERA_WIDTH = 6,
  parameter int CLK_DIV      = 4,
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [CAMERA_WIDTH-1:0] camera_y_req,
  output logic                    p_tick,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    video_on,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    vblank,
  output logic                    frame_start,
  output logic [CAMERA_WIDTH-1:0] camera_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [SCREEN_WIDTH-1:0] L_H_LAST     = SCREEN_WIDTH'(H_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] L_V_LAST     = SCREEN_WIDTH'(V_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] L_H_DISP     = SCREEN_WIDTH'(H_DISPLAY);
  localparam logic [SCREEN_WIDTH-1:0] L_V_DISP     = SCREEN_WIDTH'(V_DISPLAY);
  localparam logic [SCREEN_WIDTH-1:0] L_HS_START   = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] L_HS_END     = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [SCREEN_WIDTH-1:0] L_VS_START   = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] L_VS_END     = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic                    w_p_tick;
  logic                    w_h_wrap;
  logic [SCREEN_WIDTH-1:0] w_h_next;
  logic [SCREEN_WIDTH-1:0] w_v_next;
  logic                    w_hs_active;
  logic                    w_vs_active;

  logic [SCREEN_WIDTH-1:0] r_h_cnt;
  logic [SCREEN_WIDTH-1:0] r_v_cnt;

  // Pixel divider. With CLK_DIV = 1 every sys_clk is a pixel, so no counter.
  generate
    if (CLK_DIV == 1) begin : g_nodiv
      assign w_p_tick = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] r_div_cnt;

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          r_div_cnt <= '0;
        end else if (r_div_cnt == L_DIV_LAST) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end

      assign w_p_tick = (r_div_cnt == L_DIV_LAST);
    end
  endgenerate

  assign p_tick = w_p_tick;

  // Next raster position; every registered output is derived from these so
  // that all outputs move together on the same p_tick edge.
  assign w_h_wrap = (r_h_cnt == L_H_LAST);
  assign w_h_next = w_h_wrap ? '0 : (r_h_cnt + SCREEN_WIDTH'(1));

  always_comb begin
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      if (r_v_cnt == L_V_LAST) begin
        w_v_next = '0;
      end else begin
        w_v_next = r_v_cnt + SCREEN_WIDTH'(1);
      end
    end
  end

  assign w_hs_active = (w_h_next >= L_HS_START) && (w_h_next <= L_HS_END);
  assign w_vs_active = (w_v_next >= L_VS_START) && (w_v_next <= L_VS_END);

  // Reset parks the counters on the last pixel of the last line so the very
  // first tick lands on (0,0) and the first frame is complete.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_h_cnt     <= L_H_LAST;
      r_v_cnt     <= L_V_LAST;
      x           <= L_H_LAST;
      y           <= L_V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
      camera_y    <= '0;
    end else begin
      frame_start <= 1'b0;
      if (w_p_tick) begin
        r_h_cnt     <= w_h_next;
        r_v_cnt     <= w_v_next;
        x           <= w_h_next;
        y           <= w_v_next;
        hsync       <= ~w_hs_active;
        vsync       <= ~w_vs_active;
        video_on    <= (w_h_next < L_H_DISP) && (w_v_next < L_V_DISP);
        vblank      <= (w_v_next >= L_V_DISP);
        frame_start <= (w_h_next == '0) && (w_v_next == '0);
        // Latch on entry to the first blank line so the value is stable for
        // every visible line of the following frame.
        if ((w_h_next == '0) && (w_v_next == L_V_DISP)) begin
          camera_y <= camera_y_req;
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from `sys_clk`: pixel-enable tick, horizontal/vertical counters, sync pulses, the `x`/`y`/`video_on` scan position consumed by the pixel generator, and a tear-free `camera_y` that only changes during vertical blank. It sits directly upstream of the pixel generator. It drives the VGA port's `hsync`/`vsync` alongside the pixel generator's `rgb`.

## Interface
- `SCREEN_WIDTH`, 10: width of `x`, `y` and the internal h/v counters.
- `CAMERA_WIDTH`, 6: width of `camera_y_req` and `camera_y`.
- `CLK_DIV`, 4: `sys_clk` cycles per pixel. Must be ≥1; 100 MHz / 4 = 25 MHz.
- `H_DISPLAY` 640, `H_FRONT` 16, `H_SYNC` 96, `H_BACK` 48: horizontal timing in pixels. H_TOTAL = 800.
- `V_DISPLAY` 480, `V_FRONT` 10, `V_SYNC` 2, `V_BACK` 33: vertical timing in lines. V_TOTAL = 525.

Ports:
- `sys_clk` in 1: system clock, the only clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `camera_y_req` in CAMERA_WIDTH: camera block index requested by game logic; may change at any time.
- `p_tick` out 1: one-`sys_clk` pixel-enable pulse.
- `x` out SCREEN_WIDTH: current horizontal count, 0..H_TOTAL-1.
- `y` out SCREEN_WIDTH: current vertical count, 0..V_TOTAL-1.
- `video_on` out 1: high when `x` < H_DISPLAY and `y` < V_DISPLAY.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `vblank` out 1: high when `y` ≥ V_DISPLAY.
- `frame_start` out 1: one-`sys_clk` pulse when the position becomes (0,0).
- `camera_y` out CAMERA_WIDTH: camera index frozen for the current frame.

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1 and wraps. `p_tick` = (`div_cnt` == CLK_DIV-1), decoded combinationally. When CLK_DIV = 1, `p_tick` is constantly high.
- **Horizontal counter.** On each `sys_clk` edge with `p_tick`=1, `h_cnt` advances. At H_TOTAL-1 it wraps to 0, otherwise it increments.
- **Vertical counter.** `v_cnt` advances only when `h_cnt` wraps. At V_TOTAL-1 it wraps to 0, otherwise it increments.
- **Registered outputs.** `x`, `y`, `hsync`, `vsync`, `video_on`, `vblank` are registers loaded on `p_tick` from the *next* counter values, so all are mutually aligned and glitch-free.
  - `hsync` = 0 iff next_h ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - `vsync` = 0 iff next_v ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- **frame_start.** A register set for exactly one `sys_clk` on the `p_tick` edge where next position = (0,0); cleared on the following cycle.
- **Camera latch.** On the `p_tick` edge where next position = (0, V_DISPLAY), `camera_y` ← `camera_y_req`. No other event changes `camera_y`, so it is constant across all visible lines of a frame.
- **Arithmetic.** Counters are unsigned SCREEN_WIDTH bits. Compare boundaries are computed from parameters at elaboration. No counter ever reaches H_TOTAL or V_TOTAL.

## Timing
- **Reset values** (asynchronous, while `sys_rst`=1):
  - `div_cnt`=0, `h_cnt`/`x`=H_TOTAL-1 (799), `v_cnt`/`y`=V_TOTAL-1 (524).
  - `hsync`=1, `vsync`=1, `video_on`=0, `vblank`=1, `frame_start`=0, `camera_y`=0.
  - `p_tick`=0 when CLK_DIV > 1.
- **After reset release**: the first `p_tick` occurs on the CLK_DIV-th `sys_clk` edge. That edge moves to (0,0), sets `video_on`=1 and `vblank`=0, and pulses `frame_start`. The first frame is therefore always complete.
- **Output latency**: all registered outputs change only on `p_tick` edges. `x`/`y` hold for CLK_DIV `sys_clk` cycles each.
- **Line and frame length**: a line is H_TOTAL·CLK_DIV = 3200 `sys_clk`. A frame is 525 lines = 1,680,000 `sys_clk`.
- **Sync pulse widths**: `hsync` low for 96 pixels per line. `vsync` low for 2 full lines, with its edges coincident with `x`=0.
- **`camera_y_req` sampling**: only the value present on the latch edge (entry to line 480, `x`=0) is used. A change on that same edge is captured; a change one cycle later waits a full frame.
- **Reset mid-frame**: asynchronous return to the reset values above. Resumes as after power-up, with no partial `frame_start`.

## Test plan
- Reset held 5 cycles then released, CLK_DIV=4 → `p_tick` first high at `sys_clk` edge 4 after release, where (`x`,`y`)=(0,0), `frame_start`=1 for one cycle, `video_on`=1, `hsync`=`vsync`=1.
- Run one line → `p_tick` period is 4 cycles. `hsync` falls when `x`=656 and rises when `x`=752. `video_on` falls when `x`=640. `x` wraps 799→0 and `y` increments.
- Run a full frame → `vsync` low exactly while `y`∈{490,491}. `vblank` rises at `y`=480. Next `frame_start` occurs 1,680,000 cycles after the first.
- `camera_y_req`=5 before line 480, changed to 9 at (`x`=100,`y`=10) → `camera_y` stays at the previously latched value until (0,480), then becomes 9; the value 5 is never seen if replaced before the latch.
- Assert `sys_rst` at (`x`=300,`y`=200) → outputs take reset values immediately (asynchronous). After release, timing restarts with a fresh `frame_start`.
- CLK_DIV=1 parameter override → `p_tick` constantly 1. `x` increments every cycle. Line period is 800 cycles.
